// File: rtl/sys_bus_arbiter_pkg.sv
// Shared types and constants for the system bus arbiter slice.
package bus_pkg;

    // Access size encoding on sys_bus.size; 2'b11 has no legal meaning.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_t;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_t;

    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // A request is unusable when it asks for both or neither direction,
    // or carries the reserved size code.
    function automatic logic req_illegal(input logic rd, input logic wr,
                                         input logic [1:0] size);
        return (rd == wr) || (size == SIZE_ILLEGAL);
    endfunction

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Shared system bus: one primary drives strobes/address/data, one
// secondary answers with rdata/error by the last strobe cycle.
interface sys_bus #(
    parameter int unsigned WIDTH = 32
) (
    input logic clk
);

    logic             rd;
    logic             wr;
    logic [1:0]       size;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             error;

    modport primary (
        input  rdata, error,
        output rd, wr, size, addr, wdata
    );

    modport secondary (
        input  clk, rd, wr, size, addr, wdata,
        output rdata, error
    );

endinterface

// File: rtl/sys_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: searches from last+1 upward,
// wrapping modulo N, and returns the first active requester.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int unsigned   cand;
    logic [IW-1:0] ci;

    // Walk the N candidates in priority order; first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        ci      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last_i) + k) % N;
            ci   = IW'(cand);
            if (!valid_o && req_i[ci]) begin
                valid_o   = 1'b1;
                gnt_o[ci] = 1'b1;
                idx_o     = ci;
            end
        end
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one sys_bus primary port between NUM_REQ
// requesters. One transaction in flight: latch winner, hold the bus for
// WAIT_CYCLES+1 cycles, capture the response, pulse done to the winner.
module sys_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       m_req,
    input  logic [NUM_REQ-1:0]       m_wr,
    input  logic [NUM_REQ-1:0]       m_rd,
    input  logic [2*NUM_REQ-1:0]     m_size,
    input  logic [NUM_REQ*WIDTH-1:0] m_addr,
    input  logic [NUM_REQ*WIDTH-1:0] m_wdata,
    output logic [NUM_REQ-1:0]       m_gnt,
    output logic [NUM_REQ-1:0]       m_done,
    output logic [WIDTH-1:0]         m_rdata,
    output logic                     m_error,
    sys_bus.primary                  bus
);

    localparam int unsigned   IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
    localparam logic [3:0]    WAIT_END = 4'(WAIT_CYCLES);

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic               illegal_q, illegal_d;
    logic [1:0]         size_q, size_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]         wait_q, wait_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               error_q, error_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;

    logic               win_wr;
    logic               win_rd;
    logic [1:0]         win_size;
    logic [WIDTH-1:0]   win_addr;
    logic [WIDTH-1:0]   win_wdata;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (m_req),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Route the current round-robin winner's request fields.
    always_comb begin
        win_wr    = 1'b0;
        win_rd    = 1'b0;
        win_size  = '0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                win_wr    = m_wr[i];
                win_rd    = m_rd[i];
                win_size  = m_size[2*i +: 2];
                win_addr  = m_addr[WIDTH*i +: WIDTH];
                win_wdata = m_wdata[WIDTH*i +: WIDTH];
            end
        end
    end

    // Next-state and datapath updates for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        wr_d      = wr_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = ACCESS;
                    last_d    = pick_idx;
                    gnt_d     = pick_gnt;
                    wr_d      = win_wr;
                    rd_d      = win_rd;
                    illegal_d = req_illegal(win_rd, win_wr, win_size);
                    size_d    = win_size;
                    addr_d    = win_addr;
                    wdata_d   = win_wdata;
                    wait_d    = '0;
                end
            end
            ACCESS: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == WAIT_END) begin
                    state_d = RESP;
                    done_d  = gnt_q;
                    rdata_d = illegal_q ? '0 : bus.rdata;
                    error_d = illegal_q | bus.error;
                end
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and latch registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= LAST_RST;
            gnt_q     <= '0;
            done_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            illegal_q <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_q    <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    // Bus is driven only from latched request state, and only in ACCESS;
    // an illegal request keeps both strobes low.
    assign bus.rd    = (state_q == ACCESS) && rd_q && !illegal_q;
    assign bus.wr    = (state_q == ACCESS) && wr_q && !illegal_q;
    assign bus.size  = (state_q == ACCESS) ? size_q  : '0;
    assign bus.addr  = (state_q == ACCESS) ? addr_q  : '0;
    assign bus.wdata = (state_q == ACCESS) ? wdata_q : '0;

    assign m_gnt   = gnt_q;
    assign m_done  = done_q;
    assign m_rdata = rdata_q;
    assign m_error = error_q;

endmodule
